// File: rtl/data_frame_parser.sv
// Receive side of the trigger data-frame stream: validates header/data/footer, forwards samples, reports metadata.
// Optional statistics counters are built when DATA_FRAME_PARSER_STATS_EN is defined.
module data_frame_parser #(
    parameter int         CHANNEL_ID             = 0,
    parameter int         MAX_FRAME_LENGTH       = 200,
    parameter int         TIME_STAMP_WIDTH       = 48,
    parameter int         FIRST_TIME_STAMP_WIDTH = 32,
    parameter int         DIN_WIDTH              = 64,
    parameter logic [7:0] HEADER_ID              = 8'hAA,
    parameter logic [7:0] FOOTER_ID              = 8'h55
) (
    input  logic                        RD_CLK,
    input  logic                        RD_RESET,
    input  logic [DIN_WIDTH-1:0]        DIN,
    input  logic                        iVALID,
    output logic                        oREADY,
    output logic [DIN_WIDTH-1:0]        SAMPLE_DATA,
    output logic                        SAMPLE_VALID,
    output logic                        SAMPLE_LAST,
    input  logic                        SAMPLE_READY,
    output logic                        FRAME_DONE,
    output logic [7:0]                  FRAME_CH,
    output logic [15:0]                 FRAME_LEN,
    output logic [TIME_STAMP_WIDTH-1:0] FRAME_TIMESTAMP,
    input  logic                        ERR_CLEAR,
    output logic [3:0]                  ERR_FLAGS
`ifdef DATA_FRAME_PARSER_STATS_EN
    ,
    output logic [31:0]                 GOOD_FRAME_CNT,
    output logic [31:0]                 ERR_FRAME_CNT
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_FOOTER, S_SKIP} state_t;

    state_t                            r_state;
    logic [15:0]                       r_remaining;
    logic [7:0]                        r_ch;
    logic [15:0]                       r_len;
    logic [FIRST_TIME_STAMP_WIDTH-1:0] r_ts_lo;

    logic        w_accept;
    logic [7:0]  w_marker;
    logic [15:0] w_len;
    logic        w_is_header;
    logic        w_is_footer;
    logic        w_len_ok;
    logic        w_ch_bad;
    logic [3:0]  w_err_set;

    // Backpressure only applies while a data word would overwrite an undrained sample.
    assign oREADY      = (r_state != S_DATA) | ~SAMPLE_VALID | SAMPLE_READY;
    assign w_accept    = iVALID & oREADY;
    assign w_marker    = DIN[63:56];
    assign w_len       = DIN[47:32];
    assign w_is_header = (w_marker == HEADER_ID);
    assign w_is_footer = (w_marker == FOOTER_ID);
    assign w_len_ok    = (w_len >= 16'd1) && (w_len <= 16'(MAX_FRAME_LENGTH));
    assign w_ch_bad    = (DIN[55:48] != 8'(CHANNEL_ID));

    always_comb begin
        w_err_set = '0;
        if (w_accept) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_header) begin
                        w_err_set[1] = ~w_len_ok;
                        w_err_set[3] = w_ch_bad;
                    end else begin
                        w_err_set[0] = 1'b1;
                    end
                end
                S_FOOTER: w_err_set[2] = ~w_is_footer;
                default:  w_err_set    = '0;
            endcase
        end
    end

    always_ff @(posedge RD_CLK or posedge RD_RESET) begin
        if (RD_RESET) begin
            r_state         <= S_IDLE;
            r_remaining     <= '0;
            r_ch            <= '0;
            r_len           <= '0;
            r_ts_lo         <= '0;
            SAMPLE_DATA     <= '0;
            SAMPLE_VALID    <= 1'b0;
            SAMPLE_LAST     <= 1'b0;
            FRAME_DONE      <= 1'b0;
            FRAME_CH        <= '0;
            FRAME_LEN       <= '0;
            FRAME_TIMESTAMP <= '0;
            ERR_FLAGS       <= '0;
        end else begin
            FRAME_DONE <= 1'b0;
            // A new error in the clearing cycle survives the clear.
            ERR_FLAGS  <= (ERR_CLEAR ? 4'b0000 : ERR_FLAGS) | w_err_set;
            if (SAMPLE_VALID && SAMPLE_READY) begin
                SAMPLE_VALID <= 1'b0;
                SAMPLE_LAST  <= 1'b0;
            end
            if (w_accept) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_is_header) begin
                            r_ch        <= DIN[55:48];
                            r_len       <= w_len;
                            r_ts_lo     <= DIN[FIRST_TIME_STAMP_WIDTH-1:0];
                            r_remaining <= w_len;
                            r_state     <= w_len_ok ? S_DATA : S_SKIP;
                        end
                    end
                    S_DATA: begin
                        SAMPLE_DATA  <= DIN;
                        SAMPLE_VALID <= 1'b1;
                        SAMPLE_LAST  <= (r_remaining == 16'd1);
                        r_remaining  <= r_remaining - 16'd1;
                        if (r_remaining == 16'd1) r_state <= S_FOOTER;
                    end
                    S_FOOTER: begin
                        if (w_is_footer) begin
                            FRAME_TIMESTAMP <= TIME_STAMP_WIDTH'({DIN[55:40], r_ts_lo});
                            FRAME_CH        <= r_ch;
                            FRAME_LEN       <= r_len;
                            FRAME_DONE      <= 1'b1;
                            r_state         <= S_IDLE;
                        end else begin
                            r_state <= S_SKIP;
                        end
                    end
                    default: begin
                        if (w_is_footer) r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef DATA_FRAME_PARSER_STATS_EN
    logic w_to_skip;
    assign w_to_skip = w_accept &
                       (((r_state == S_IDLE) & w_is_header & ~w_len_ok) |
                        ((r_state == S_FOOTER) & ~w_is_footer));

    always_ff @(posedge RD_CLK or posedge RD_RESET) begin
        if (RD_RESET) begin
            GOOD_FRAME_CNT <= '0;
            ERR_FRAME_CNT  <= '0;
        end else begin
            if (FRAME_DONE) GOOD_FRAME_CNT <= GOOD_FRAME_CNT + 32'd1;
            if (w_to_skip)  ERR_FRAME_CNT  <= ERR_FRAME_CNT + 32'd1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_data_frame_parser.sv
// Scoreboard bench for data_frame_parser: expected samples and frame metadata are queued at drive time
// and compared when the parser emits them.
module tb_data_frame_parser;

    logic        RD_CLK;
    logic        RD_RESET;
    logic [63:0] DIN;
    logic        iVALID;
    logic        oREADY;
    logic [63:0] SAMPLE_DATA;
    logic        SAMPLE_VALID;
    logic        SAMPLE_LAST;
    logic        SAMPLE_READY;
    logic        FRAME_DONE;
    logic [7:0]  FRAME_CH;
    logic [15:0] FRAME_LEN;
    logic [47:0] FRAME_TIMESTAMP;
    logic        ERR_CLEAR;
    logic [3:0]  ERR_FLAGS;

    data_frame_parser dut (
        .RD_CLK         (RD_CLK),
        .RD_RESET       (RD_RESET),
        .DIN            (DIN),
        .iVALID         (iVALID),
        .oREADY         (oREADY),
        .SAMPLE_DATA    (SAMPLE_DATA),
        .SAMPLE_VALID   (SAMPLE_VALID),
        .SAMPLE_LAST    (SAMPLE_LAST),
        .SAMPLE_READY   (SAMPLE_READY),
        .FRAME_DONE     (FRAME_DONE),
        .FRAME_CH       (FRAME_CH),
        .FRAME_LEN      (FRAME_LEN),
        .FRAME_TIMESTAMP(FRAME_TIMESTAMP),
        .ERR_CLEAR      (ERR_CLEAR),
        .ERR_FLAGS      (ERR_FLAGS)
    );

    initial RD_CLK = 1'b0;
    always #5 RD_CLK = ~RD_CLK;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    logic [64:0] sq[$];   // {last, word}
    logic [71:0] fq[$];   // {ch, len, ts}

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge RD_CLK) begin
        if (!RD_RESET) begin
            if (SAMPLE_VALID && SAMPLE_READY) begin
                if (sq.size() == 0) begin
                    check("sample_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [64:0] e;
                    e = sq.pop_front();
                    check("sample_data", SAMPLE_DATA, e[63:0]);
                    check("sample_last", 64'(SAMPLE_LAST), 64'(e[64]));
                end
            end
            if (FRAME_DONE) begin
                n_done++;
                if (fq.size() == 0) begin
                    check("done_unexpected", 64'd1, 64'd0);
                end else begin
                    logic [71:0] f;
                    f = fq.pop_front();
                    check("frame_ch",  64'(FRAME_CH),        64'(f[71:64]));
                    check("frame_len", 64'(FRAME_LEN),       64'(f[63:48]));
                    check("frame_ts",  64'(FRAME_TIMESTAMP), 64'(f[47:0]));
                end
            end
        end
    end

    task automatic send_word(input logic [63:0] w);
        int t;
        t = 0;
        DIN    = w;
        iVALID = 1'b1;
        @(negedge RD_CLK);
        while (!oREADY && t < 300) begin
            t++;
            @(negedge RD_CLK);
        end
        if (!oREADY) check("send_timeout", 64'(oREADY), 64'd1);
        @(posedge RD_CLK);
        #1;
    endtask

    task automatic go_idle();
        iVALID = 1'b0;
        DIN    = '0;
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [15:0] n,
                              input logic [47:0] ts, input logic [7:0] fmark);
        logic        good_len;
        logic [63:0] w;
        good_len = (n >= 16'd1) && (n <= 16'd200);
        send_word({8'hAA, ch, n, ts[31:0]});
        if (good_len) begin
            for (int i = 0; i < int'(n); i++) begin
                w = {$urandom(), $urandom()};
                sq.push_back({(i == int'(n) - 1), w});
                send_word(w);
            end
        end else begin
            for (int i = 0; i < 2; i++) send_word({8'h11, 24'h0, $urandom()});
        end
        if (good_len && fmark == 8'h55) fq.push_back({ch, n, ts});
        send_word({fmark, ts[47:32], 40'h0});
        if (fmark != 8'h55) begin
            send_word({8'h22, 24'h0, $urandom()});
            send_word({8'h55, 56'h0});
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && (sq.size() != 0 || fq.size() != 0); i++) @(posedge RD_CLK);
        repeat (3) @(posedge RD_CLK);
        #1;
        check("drain", 64'(sq.size() + fq.size()), 64'd0);
    endtask

    task automatic clear_errs();
        ERR_CLEAR = 1'b1;
        @(posedge RD_CLK);
        #1;
        ERR_CLEAR = 1'b0;
        check("err_cleared", 64'(ERR_FLAGS), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int          d0;
        logic [63:0] held;
        RD_RESET     = 1'b1;
        DIN          = '0;
        iVALID       = 1'b0;
        SAMPLE_READY = 1'b1;
        ERR_CLEAR    = 1'b0;
        repeat (3) @(posedge RD_CLK);
        #1;
        check("rst_oready",   64'(oREADY),          64'd1);
        check("rst_svalid",   64'(SAMPLE_VALID),    64'd0);
        check("rst_done",     64'(FRAME_DONE),      64'd0);
        check("rst_err",      64'(ERR_FLAGS),       64'd0);
        check("rst_ts",       64'(FRAME_TIMESTAMP), 64'd0);
        RD_RESET = 1'b0;
        @(posedge RD_CLK);
        #1;

        // Good frame, full-rate sink
        d0 = n_done;
        send_frame(8'd0, 16'd3, 48'h1234_89ABCDEF, 8'h55);
        go_idle();
        wait_drain();
        check("good_done_cnt", 64'(n_done - d0), 64'd1);
        check("good_err",      64'(ERR_FLAGS),   64'd0);
        check("good_len_hold", 64'(FRAME_LEN),   64'd3);

        // Same frame with a 20-cycle sink stall after the first data word
        @(posedge RD_CLK);
        #1;
        SAMPLE_READY = 1'b0;
        d0 = n_done;
        fork
            begin
                send_frame(8'd0, 16'd3, 48'h1234_89ABCDEF, 8'h55);
                go_idle();
            end
            begin
                int t;
                t = 0;
                @(negedge RD_CLK);
                while (!SAMPLE_VALID && t < 100) begin
                    t++;
                    @(negedge RD_CLK);
                end
                check("stall_valid_seen", 64'(SAMPLE_VALID), 64'd1);
                held = SAMPLE_DATA;
                for (int i = 0; i < 20; i++) begin
                    check("stall_oready", 64'(oREADY),  64'd0);
                    check("stall_data",   SAMPLE_DATA,  held);
                    @(negedge RD_CLK);
                end
                @(posedge RD_CLK);
                #1;
                SAMPLE_READY = 1'b1;
            end
        join
        wait_drain();
        check("stall_done_cnt", 64'(n_done - d0), 64'd1);

        // Out-of-range lengths
        d0 = n_done;
        send_frame(8'd0, 16'd0, 48'h0000_00000001, 8'h55);
        go_idle();
        wait_drain();
        check("n0_err", 64'(ERR_FLAGS), 64'b0010);
        clear_errs();
        send_frame(8'd0, 16'd201, 48'h0000_00000002, 8'h55);
        go_idle();
        wait_drain();
        check("n201_err",     64'(ERR_FLAGS),   64'b0010);
        check("bad_len_done", 64'(n_done - d0), 64'd0);
        clear_errs();
        d0 = n_done;
        send_frame(8'd0, 16'd200, 48'hFFFF_00000000, 8'h55);
        go_idle();
        wait_drain();
        check("after_bad_done", 64'(n_done - d0), 64'd1);
        check("after_bad_err",  64'(ERR_FLAGS),   64'd0);

        // Missing footer, then clear racing a new error
        d0 = n_done;
        send_frame(8'd0, 16'd2, 48'hABCD_00001111, 8'h00);
        go_idle();
        wait_drain();
        check("footer_err",  64'(ERR_FLAGS),   64'b0100);
        check("footer_done", 64'(n_done - d0), 64'd0);
        DIN       = {8'h33, 56'h1};
        iVALID    = 1'b1;
        ERR_CLEAR = 1'b1;
        @(posedge RD_CLK);
        #1;
        go_idle();
        ERR_CLEAR = 1'b0;
        check("clear_vs_set", 64'(ERR_FLAGS), 64'b0001);
        clear_errs();

        // Stray word then a wrong-channel frame
        d0 = n_done;
        send_word({8'h12, 56'h0});
        send_frame(8'd5, 16'd2, 48'h0102_03040506, 8'h55);
        go_idle();
        wait_drain();
        check("stray_ch_err", 64'(ERR_FLAGS),   64'b1001);
        check("ch5_done",     64'(n_done - d0), 64'd1);
        check("ch5_hold",     64'(FRAME_CH),    64'd5);
        clear_errs();

        // Back-to-back frames with no idle cycle
        d0 = n_done;
        send_frame(8'd0, 16'd1, 48'h0001_00000001, 8'h55);
        send_frame(8'd0, 16'd4, 48'h0002_00000002, 8'h55);
        go_idle();
        wait_drain();
        check("b2b_done", 64'(n_done - d0), 64'd2);
        check("b2b_err",  64'(ERR_FLAGS),   64'd0);

        // Reset in the middle of a data phase
        d0 = n_done;
        send_word({8'hAA, 8'd0, 16'd4, 32'h55667788});
        for (int i = 0; i < 2; i++) begin
            logic [63:0] w;
            w = {$urandom(), $urandom()};
            sq.push_back({1'b0, w});
            send_word(w);
        end
        go_idle();
        RD_RESET = 1'b1;
        #1;
        sq.delete();
        check("mid_rst_svalid", 64'(SAMPLE_VALID),    64'd0);
        check("mid_rst_sdata",  SAMPLE_DATA,          64'd0);
        check("mid_rst_ch",     64'(FRAME_CH),        64'd0);
        check("mid_rst_len",    64'(FRAME_LEN),       64'd0);
        check("mid_rst_ts",     64'(FRAME_TIMESTAMP), 64'd0);
        check("mid_rst_oready", 64'(oREADY),          64'd1);
        repeat (2) @(posedge RD_CLK);
        #1;
        RD_RESET = 1'b0;
        @(posedge RD_CLK);
        #1;
        send_frame(8'd0, 16'd3, 48'h7777_12345678, 8'h55);
        go_idle();
        wait_drain();
        check("post_rst_done", 64'(n_done - d0), 64'd1);
        check("post_rst_err",  64'(ERR_FLAGS),   64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
